// File: rtl/bp_io_arb_pkg.sv
// Shared types for the unicore incoming-I/O port arbiter and its response-ID FIFO.
package bp_io_arb_pkg;

  typedef logic [0:0] io_arb_cli_id_t;

  localparam int io_arb_num_cli_gp = 2;

endpackage

// File: rtl/bp_io_arb_id_fifo.sv
// In-order FIFO of client IDs, one entry per io_cmd issued and awaiting its io_resp.
module bp_io_arb_id_fifo
  import bp_io_arb_pkg::*;
#(
  parameter int els_p = 4
)
(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [0:0]              data_i,
  input  logic                    enq_i,
  input  logic                    deq_i,
  output logic [0:0]              data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(els_p):0]  count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  io_arb_cli_id_t        mem_r [els_p];
  logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]   count_r;
  logic                  enq_v, deq_v;

  assign full_o  = (count_r == full_cnt_lp);
  assign empty_o = (count_r == '0);
  assign count_o = count_r;
  assign data_o  = mem_r[rd_ptr_r];

  assign enq_v = enq_i & ~full_o;
  assign deq_v = deq_i & ~empty_o;

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_v) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq_v) rd_ptr_r <= rd_ptr_r + 1'b1;
      if (enq_v && !deq_v)      count_r <= count_r + 1'b1;
      else if (deq_v && !enq_v) count_r <= count_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_v) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_io_cmd_rr_arbiter.sv
// Round-robin share of the unicore io_cmd port between the AXI-lite host bridge (client 0)
// and the debug/loader engine (client 1); io_resp is routed back in issue order.
module bp_io_cmd_rr_arbiter
  import bp_io_arb_pkg::*;
#(
  parameter int msg_width_p = 160,
  parameter int els_p       = 4
)
(
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [io_arb_num_cli_gp*msg_width_p-1:0]  cli_cmd_i,
  input  logic [io_arb_num_cli_gp-1:0]              cli_cmd_v_i,
  output logic [io_arb_num_cli_gp-1:0]              cli_cmd_yumi_o,
  output logic [msg_width_p-1:0]                    cli_resp_o,
  output logic [io_arb_num_cli_gp-1:0]              cli_resp_v_o,
  input  logic [io_arb_num_cli_gp-1:0]              cli_resp_ready_i,
  output logic [msg_width_p-1:0]                    io_cmd_o,
  output logic                                      io_cmd_v_o,
  input  logic                                      io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]                    io_resp_i,
  input  logic                                      io_resp_v_i,
  output logic                                      io_resp_ready_o,
  output logic [$clog2(els_p):0]                    outstanding_o,
  output logic                                      err_o
);

  typedef enum logic {e_unlocked, e_locked} lock_e;

  lock_e           lock_r;
  io_arb_cli_id_t  last_grant_r, lock_grant_r, grant, head_id;
  logic            cmd_v, cmd_hs, resp_hs;
  logic            fifo_full, fifo_empty;
  logic            err_r;

  // A locked grant is replayed until yumi so a presented cmd is never withdrawn or swapped.
  always_comb begin
    grant = lock_grant_r;
    cmd_v = 1'b0;
    if (lock_r == e_locked) begin
      cmd_v = 1'b1;
    end else if (!fifo_full && (cli_cmd_v_i != '0)) begin
      cmd_v = 1'b1;
      if (&cli_cmd_v_i) grant = ~last_grant_r;
      else              grant = cli_cmd_v_i[1];
    end
  end

  assign cmd_hs     = cmd_v & io_cmd_yumi_i;
  assign io_cmd_v_o = cmd_v & reset_n_i;
  assign io_cmd_o   = grant[0] ? cli_cmd_i[2*msg_width_p-1:msg_width_p]
                               : cli_cmd_i[msg_width_p-1:0];

  always_comb begin
    cli_cmd_yumi_o        = '0;
    cli_cmd_yumi_o[grant] = cmd_hs & reset_n_i;
  end

  assign io_resp_ready_o = ~fifo_empty & cli_resp_ready_i[head_id];
  assign resp_hs         = io_resp_v_i & io_resp_ready_o;
  assign cli_resp_o      = io_resp_i;

  always_comb begin
    cli_resp_v_o          = '0;
    cli_resp_v_o[head_id] = io_resp_v_i & ~fifo_empty;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_r       <= e_unlocked;
      last_grant_r <= 1'b1;
      lock_grant_r <= '0;
      err_r        <= 1'b0;
    end else begin
      if (cmd_hs) begin
        lock_r       <= e_unlocked;
        last_grant_r <= grant;
      end else if (cmd_v) begin
        lock_r       <= e_locked;
        lock_grant_r <= grant;
      end
      if (io_resp_v_i && fifo_empty) err_r <= 1'b1;
    end
  end

  assign err_o = err_r;

  bp_io_arb_id_fifo #(.els_p(els_p)) id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (grant),
    .enq_i     (cmd_hs),
    .deq_i     (resp_hs),
    .data_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding_o)
  );

  assert property (@(posedge clk_i) disable iff (!reset_n_i) io_cmd_yumi_i |-> io_cmd_v_o);
  assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(cli_resp_v_o));

  for (genvar i = 0; i < io_arb_num_cli_gp; i++) begin : g_hold
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                     cli_cmd_v_i[i] && !cli_cmd_yumi_o[i] |=> cli_cmd_v_i[i]);
  end

endmodule

// File: tb/tb_bp_io_cmd_rr_arbiter.sv
// Directed and randomized bench for bp_io_cmd_rr_arbiter against a queue-based model.
module tb_bp_io_cmd_rr_arbiter;

  localparam int W   = 160;
  localparam int ELS = 4;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b1;
  logic [2*W-1:0]   cli_cmd_i = '0;
  logic [1:0]       cli_cmd_v_i = '0;
  logic [1:0]       cli_cmd_yumi_o;
  logic [W-1:0]     cli_resp_o;
  logic [1:0]       cli_resp_v_o;
  logic [1:0]       cli_resp_ready_i = '0;
  logic [W-1:0]     io_cmd_o;
  logic             io_cmd_v_o;
  logic             io_cmd_yumi_i = 1'b0;
  logic [W-1:0]     io_resp_i = '0;
  logic             io_resp_v_i = 1'b0;
  logic             io_resp_ready_o;
  logic [2:0]       outstanding_o;
  logic             err_o;

  bp_io_cmd_rr_arbiter #(.msg_width_p(W), .els_p(ELS)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .cli_cmd_i        (cli_cmd_i),
    .cli_cmd_v_i      (cli_cmd_v_i),
    .cli_cmd_yumi_o   (cli_cmd_yumi_o),
    .cli_resp_o       (cli_resp_o),
    .cli_resp_v_o     (cli_resp_v_o),
    .cli_resp_ready_i (cli_resp_ready_i),
    .io_cmd_o         (io_cmd_o),
    .io_cmd_v_o       (io_cmd_v_o),
    .io_cmd_yumi_i    (io_cmd_yumi_i),
    .io_resp_i        (io_resp_i),
    .io_resp_v_i      (io_resp_v_i),
    .io_resp_ready_o  (io_resp_ready_o),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: issued-but-unanswered client IDs in order, plus arbitration history.
  int           id_q[$];
  int           last_g = 1;
  bit           locked = 1'b0;
  int           lock_g = 0;
  bit           err_m = 1'b0;
  bit           pend[2];
  logic [W-1:0] pay[2];
  logic [W-1:0] resp_msg = '0;
  bit           exp_v;
  int           exp_g;

  logic [1:0]   rw, rrdy;
  logic         ry, rv;

  function automatic logic [W-1:0] rand_msg();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void predict();
    exp_v = 1'b0;
    exp_g = lock_g;
    if (locked) begin
      exp_v = 1'b1;
    end else if (id_q.size() < ELS && (pend[0] || pend[1])) begin
      exp_v = 1'b1;
      if (pend[0] && pend[1]) exp_g = 1 - last_g;
      else                    exp_g = pend[1] ? 1 : 0;
    end
  endfunction

  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] exp_yumi;
    logic [1:0] exp_rv;
    logic       exp_rdy;
    exp_yumi = '0;
    exp_rv   = '0;
    exp_rdy  = 1'b0;
    if (exp_v && io_cmd_yumi_i) exp_yumi[exp_g] = 1'b1;
    if (id_q.size() != 0) begin
      exp_rdy          = cli_resp_ready_i[id_q[0]];
      exp_rv[id_q[0]]  = io_resp_v_i;
    end
    checkValue("io_cmd_v", W'(io_cmd_v_o), W'(exp_v));
    if (exp_v) checkValue("io_cmd", io_cmd_o, pay[exp_g]);
    checkValue("cli_cmd_yumi", W'(cli_cmd_yumi_o), W'(exp_yumi));
    checkValue("io_resp_ready", W'(io_resp_ready_o), W'(exp_rdy));
    checkValue("cli_resp_v", W'(cli_resp_v_o), W'(exp_rv));
    checkValue("cli_resp", cli_resp_o, resp_msg);
    checkValue("outstanding", W'(outstanding_o), W'(id_q.size()));
    checkValue("err", W'(err_o), W'(err_m));
  endtask

  // One clock cycle: drive at negedge, check, then advance the model past the posedge.
  task automatic applyStimulus(input logic [1:0] want, input logic yumi,
                               input logic rvalid, input logic [1:0] ready);
    bit deq;
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && want[i]) begin
        pend[i] = 1'b1;
        pay[i]  = rand_msg();
      end
    end
    cli_cmd_v_i      = {pend[1], pend[0]};
    cli_cmd_i        = {pay[1], pay[0]};
    predict();
    io_cmd_yumi_i    = yumi & exp_v;
    resp_msg         = rand_msg();
    io_resp_i        = resp_msg;
    io_resp_v_i      = rvalid;
    cli_resp_ready_i = ready;
    #1;
    checkOutput();
    deq = rvalid && id_q.size() != 0 && ready[id_q[0]];
    if (rvalid && id_q.size() == 0) err_m = 1'b1;
    if (deq) void'(id_q.pop_front());
    if (exp_v && io_cmd_yumi_i) begin
      id_q.push_back(exp_g);
      last_g      = exp_g;
      locked      = 1'b0;
      pend[exp_g] = 1'b0;
    end else if (exp_v) begin
      locked = 1'b1;
      lock_g = exp_g;
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    reset_n_i        = 1'b0;
    pend[0]          = 1'b0;
    pend[1]          = 1'b0;
    pay[0]           = '0;
    pay[1]           = '0;
    cli_cmd_v_i      = '0;
    cli_cmd_i        = '0;
    io_cmd_yumi_i    = 1'b0;
    io_resp_v_i      = 1'b0;
    resp_msg         = '0;
    io_resp_i        = '0;
    cli_resp_ready_i = '0;
    id_q.delete();
    last_g = 1;
    locked = 1'b0;
    lock_g = 0;
    err_m  = 1'b0;
    #1;
    checkValue("rst_io_cmd_v", W'(io_cmd_v_o), W'(0));
    checkValue("rst_io_cmd", io_cmd_o, '0);
    checkValue("rst_cmd_yumi", W'(cli_cmd_yumi_o), W'(0));
    checkValue("rst_resp_v", W'(cli_resp_v_o), W'(0));
    checkValue("rst_resp_ready", W'(io_resp_ready_o), W'(0));
    checkValue("rst_outstanding", W'(outstanding_o), W'(0));
    checkValue("rst_err", W'(err_o), W'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    $display("[TB] client 0 alone, three cmds then three resps");
    repeat (3) applyStimulus(2'b01, 1'b1, 1'b0, 2'b11);
    repeat (3) applyStimulus(2'b00, 1'b0, 1'b1, 2'b11);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);

    $display("[TB] both clients valid, grants alternate");
    doReset();
    repeat (4) applyStimulus(2'b11, 1'b1, 1'b0, 2'b11);
    repeat (4) applyStimulus(2'b00, 1'b0, 1'b1, 2'b11);

    $display("[TB] lock holds client 1 until yumi");
    doReset();
    repeat (2) applyStimulus(2'b10, 1'b0, 1'b0, 2'b11);
    repeat (3) applyStimulus(2'b11, 1'b0, 1'b0, 2'b11);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b11);
    applyStimulus(2'b00, 1'b1, 1'b0, 2'b11);

    $display("[TB] full FIFO blocks issue, no bypass");
    doReset();
    repeat (4) applyStimulus(2'b01, 1'b1, 1'b0, 2'b11);
    repeat (2) applyStimulus(2'b01, 1'b1, 1'b0, 2'b11);
    applyStimulus(2'b01, 1'b1, 1'b1, 2'b11);
    applyStimulus(2'b01, 1'b1, 1'b0, 2'b11);

    $display("[TB] head client not ready holds the response");
    doReset();
    applyStimulus(2'b10, 1'b1, 1'b0, 2'b11);
    repeat (2) applyStimulus(2'b00, 1'b0, 1'b1, 2'b01);
    applyStimulus(2'b00, 1'b0, 1'b1, 2'b11);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);

    $display("[TB] randomized traffic");
    doReset();
    for (int n = 0; n < 400; n++) begin
      rw   = 2'($urandom_range(0, 3));
      ry   = 1'($urandom_range(0, 1));
      rv   = (id_q.size() != 0) && ($urandom_range(0, 2) != 0);
      rrdy = 2'($urandom_range(0, 3));
      applyStimulus(rw, ry, rv, rrdy);
    end

    $display("[TB] response with empty FIFO, then reset mid-stream");
    doReset();
    applyStimulus(2'b00, 1'b0, 1'b1, 2'b11);
    repeat (2) applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);
    applyStimulus(2'b01, 1'b1, 1'b0, 2'b11);
    applyStimulus(2'b01, 1'b0, 1'b0, 2'b11);
    doReset();
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
